rgb_frame_seq: RTL and testbench

//  Frame sequencer for the WS2812b serial-input bit stage. Consumes per-bit strobes and stream resets,

---
 rtl/rgb_frame_seq_if.sv | 27 ++
 rtl/rgb_frame_seq.sv | 182 ++++++++++++++++++
 tb/tb_rgb_frame_seq.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rgb_frame_seq_if.sv
// Pixel word handshake between the frame sequencer and the RGB->RGBW path.
// Ports: pix_data/pix_idx/pix_valid from master, pix_ready from slave.
interface rgb_frame_seq_if #(
  parameter int NUM_LEDS     = 60,
  parameter int BITS_PER_LED = 24
);
  localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  logic [BITS_PER_LED-1:0] pix_data;
  logic [IDX_W-1:0]        pix_idx;
  logic                    pix_valid;
  logic                    pix_ready;

  modport master (
    output pix_data,
    output pix_idx,
    output pix_valid,
    input  pix_ready
  );

  modport slave (
    input  pix_data,
    input  pix_idx,
    input  pix_valid,
    output pix_ready
  );
endinterface

// File: rtl/rgb_frame_seq.sv
// WS2812b frame sequencer: assembles GRB words from bit strobes, tags LED index.
// Ports: clk, rst (sync, active-high), bit_in/bit_strobe/bit_stream_reset in,
//   pix (master: pix_data, pix_idx, pix_valid, pix_ready), frame_start,
//   frame_done, short_frame (1-clk pulses), overflow (sticky).
//   Macro RGB_FRAME_SEQ_STATS_EN adds frame_cnt[15:0] and short_cnt[7:0].
module rgb_frame_seq #(
  parameter int NUM_LEDS     = 60,
  parameter int BITS_PER_LED = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_in,
  input  logic bit_strobe,
  input  logic bit_stream_reset,
  rgb_frame_seq_if.master pix,
  output logic frame_start,
  output logic frame_done,
  output logic short_frame,
  output logic overflow
`ifdef RGB_FRAME_SEQ_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [7:0]  short_cnt
`endif
);
  localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int CNT_W = (BITS_PER_LED > 1) ? $clog2(BITS_PER_LED) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEDS - 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITS_PER_LED - 1);

  typedef enum logic [1:0] {
    SYNC,
    COLLECT,
    DONE
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [BITS_PER_LED-1:0] shreg_q;
  logic [BITS_PER_LED-1:0] shreg_d;
  logic [CNT_W-1:0]        bit_cnt_q;
  logic [CNT_W-1:0]        bit_cnt_d;
  logic [IDX_W-1:0]        led_idx_q;
  logic [IDX_W-1:0]        led_idx_d;
  logic [BITS_PER_LED-1:0] data_q;
  logic [BITS_PER_LED-1:0] data_d;
  logic [IDX_W-1:0]        idx_q;
  logic [IDX_W-1:0]        idx_d;
  logic                    valid_q;
  logic                    valid_d;
  logic                    fs_q;
  logic                    fs_d;
  logic                    fd_q;
  logic                    fd_d;
  logic                    sf_q;
  logic                    sf_d;
  logic                    ovf_q;
  logic                    ovf_d;

  logic                    sr_evt;
  logic                    bit_evt;
  logic                    can_load;
  logic [BITS_PER_LED-1:0] word;

  assign sr_evt   = bit_strobe & bit_stream_reset;
  assign bit_evt  = bit_strobe & ~bit_stream_reset
                  & (state_q == COLLECT);
  // Slot is free if empty or being drained this very cycle.
  assign can_load = ~valid_q | pix.pix_ready;
  assign word     = {shreg_q[BITS_PER_LED-2:0], bit_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SYNC;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      led_idx_q <= '0;
      data_q    <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      fs_q      <= 1'b0;
      fd_q      <= 1'b0;
      sf_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      led_idx_q <= led_idx_d;
      data_q    <= data_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      fs_q      <= fs_d;
      fd_q      <= fd_d;
      sf_q      <= sf_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    led_idx_d = led_idx_q;
    data_d    = data_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    fs_d      = 1'b0;
    fd_d      = 1'b0;
    sf_d      = 1'b0;
    ovf_d     = ovf_q;

    if (valid_q && pix.pix_ready) begin
      valid_d = 1'b0;
    end

    unique case (1'b1)
      sr_evt: begin
        state_d   = COLLECT;
        shreg_d   = '0;
        bit_cnt_d = '0;
        led_idx_d = '0;
        fs_d      = 1'b1;
        sf_d      = (state_q == COLLECT)
                  && ((led_idx_q != '0)
                  || (bit_cnt_q != '0));
      end
      bit_evt: begin
        shreg_d = word;
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d = '0;
          if (led_idx_q == LAST_IDX) begin
            state_d = DONE;
            fd_d    = 1'b1;
          end else begin
            led_idx_d = led_idx_q + IDX_W'(1);
          end
          if (can_load) begin
            data_d  = word;
            idx_d   = led_idx_q;
            valid_d = 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign pix.pix_data  = data_q;
  assign pix.pix_idx   = idx_q;
  assign pix.pix_valid = valid_q;
  assign frame_start   = fs_q;
  assign frame_done    = fd_q;
  assign short_frame   = sf_q;
  assign overflow      = ovf_q;

`ifdef RGB_FRAME_SEQ_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [7:0]  short_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      short_cnt_q <= '0;
    end else begin
      if (fd_d) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      if (sf_d && (short_cnt_q != 8'hFF)) begin
        short_cnt_q <= short_cnt_q + 8'd1;
      end
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign short_cnt = short_cnt_q;
`endif
endmodule

// File: tb/tb_rgb_frame_seq.sv
// Testbench for rgb_frame_seq with a frame-position reference model.
// Drives bit strobes and pix_ready; compares pulses, handshake and words.
module tb_rgb_frame_seq;
  localparam int N = 3;
  localparam int W = 24;

  logic clk = 1'b0;
  logic rst;
  logic bit_in;
  logic bit_strobe;
  logic bit_stream_reset;
  logic frame_start;
  logic frame_done;
  logic short_frame;
  logic overflow;
`ifdef RGB_FRAME_SEQ_STATS_EN
  logic [15:0] frame_cnt;
  logic [7:0]  short_cnt;
`endif

  rgb_frame_seq_if #(.NUM_LEDS(N), .BITS_PER_LED(W)) pix_if ();

  rgb_frame_seq #(.NUM_LEDS(N), .BITS_PER_LED(W)) dut (
    .clk              (clk),
    .rst              (rst),
    .bit_in           (bit_in),
    .bit_strobe       (bit_strobe),
    .bit_stream_reset (bit_stream_reset),
    .pix              (pix_if),
    .frame_start      (frame_start),
    .frame_done       (frame_done),
    .short_frame      (short_frame),
    .overflow         (overflow)
`ifdef RGB_FRAME_SEQ_STATS_EN
    ,
    .frame_cnt        (frame_cnt),
    .short_cnt        (short_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Reference: position counted in bits since the last stream reset.
  bit          m_coll;
  int          m_pos;
  logic [23:0] m_acc;
  bit          m_valid;
  logic [23:0] m_data;
  logic [1:0]  m_idx;
  bit          m_ovf;
  bit          m_fs;
  bit          m_fd;
  bit          m_sf;

  task automatic step(input bit s, input bit sr, input bit b,
                      input bit rdy, input bit r);
    bit take;
    bit loaded;
    int k;
    @(negedge clk);
    rst              = r;
    bit_strobe       = s;
    bit_stream_reset = sr;
    bit_in           = b;
    pix_if.pix_ready = rdy;
    @(posedge clk);
    m_fs = 0;
    m_fd = 0;
    m_sf = 0;
    if (r) begin
      m_coll = 0; m_pos = 0; m_acc = '0; m_valid = 0;
      m_data = '0; m_idx = '0; m_ovf = 0;
    end else begin
      take   = m_valid && rdy;
      loaded = 0;
      if (s && sr) begin
        m_fs   = 1;
        m_sf   = m_coll && (m_pos != 0);
        m_coll = 1;
        m_pos  = 0;
        m_acc  = '0;
      end else if (s && m_coll) begin
        m_acc = {m_acc[22:0], b};
        m_pos++;
        if (m_pos % W == 0) begin
          k = m_pos / W - 1;
          if (k == N - 1) begin
            m_fd   = 1;
            m_coll = 0;
          end
          if (!m_valid || rdy) begin
            m_data = m_acc;
            m_idx  = 2'(k);
            loaded = 1;
          end else begin
            m_ovf = 1;
          end
        end
      end
      if (loaded) m_valid = 1;
      else if (take) m_valid = 0;
    end
    #1;
  endtask

  task automatic send_word(input logic [23:0] w, input bit rdy);
    for (int i = W - 1; i >= 0; i--) step(1, 0, w[i], rdy, 0);
  endtask

  task automatic test_reset();
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    vectors++;
    if (pix_if.pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %b exp 0", pix_if.pix_valid);
    end
    vectors++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_overflow got %b exp 0", overflow);
    end
    vectors++;
    if ({frame_start, frame_done, short_frame} !== 3'b000) begin
      errors++;
      $display("FAIL reset_pulses got %b%b%b exp 000",
               frame_start, frame_done, short_frame);
    end
    vectors++;
    if ({pix_if.pix_data, pix_if.pix_idx} !== 26'd0) begin
      errors++;
      $display("FAIL reset_data got %h/%0d exp 0/0",
               pix_if.pix_data, pix_if.pix_idx);
    end
    step(0, 0, 0, 0, 0);
  endtask

  task automatic test_sync_ignore();
    for (int i = 0; i < W; i++) begin
      step(1, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      vectors++;
      if ({pix_if.pix_valid, frame_start, frame_done, short_frame}
          !== 4'b0000) begin
        errors++;
        $display("FAIL sync_ignore bit %0d got v%b fs%b fd%b sf%b exp 0",
                 i, pix_if.pix_valid, frame_start, frame_done, short_frame);
      end
    end
  endtask

  task automatic test_single_word();
    logic [23:0] w;
    w = 24'hA5C33C;
    step(1, 1, 0, 1, 0);
    vectors++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL single_fs got %b exp 1", frame_start);
    end
    for (int i = W - 1; i >= 0; i--) begin
      step(1, 0, w[i], 1, 0);
      if (i == W - 1) begin
        vectors++;
        if (frame_start !== 1'b0) begin
          errors++;
          $display("FAIL single_fs_width got %b exp 0", frame_start);
        end
      end
      if (i > 0) begin
        vectors++;
        if (pix_if.pix_valid !== 1'b0) begin
          errors++;
          $display("FAIL single_early bit %0d got %b exp 0",
                   i, pix_if.pix_valid);
        end
      end
    end
    vectors++;
    if ({pix_if.pix_valid, pix_if.pix_data, pix_if.pix_idx}
        !== {1'b1, 24'hA5C33C, 2'd0}) begin
      errors++;
      $display("FAIL single_word got v%b %h idx%0d exp v1 a5c33c idx0",
               pix_if.pix_valid, pix_if.pix_data, pix_if.pix_idx);
    end
    step(0, 0, 0, 1, 0);
    vectors++;
    if (pix_if.pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_accept got %b exp 0", pix_if.pix_valid);
    end
  endtask

  task automatic test_frame_done();
    logic [23:0] w;
    step(1, 1, 0, 1, 0);
    for (int n = 0; n < 4; n++) begin
      w = 24'($urandom);
      send_word(w, 1);
      if (n < N) begin
        vectors++;
        if ({pix_if.pix_valid, pix_if.pix_data, pix_if.pix_idx}
            !== {1'b1, w, 2'(n)}) begin
          errors++;
          $display("FAIL fd_word %0d got v%b %h idx%0d exp v1 %h idx%0d",
                   n, pix_if.pix_valid, pix_if.pix_data,
                   pix_if.pix_idx, w, n);
        end
        vectors++;
        if (frame_done !== (n == N - 1)) begin
          errors++;
          $display("FAIL fd_pulse word %0d got %b exp %b",
                   n, frame_done, (n == N - 1));
        end
      end else begin
        vectors++;
        if ({pix_if.pix_valid, frame_done} !== 2'b00) begin
          errors++;
          $display("FAIL fd_extra got v%b fd%b exp v0 fd0",
                   pix_if.pix_valid, frame_done);
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [23:0] a;
    logic [23:0] b;
    a = 24'h123456;
    b = 24'hFEDCBA;
    step(0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0);
    send_word(a, 0);
    vectors++;
    if ({pix_if.pix_valid, pix_if.pix_data, overflow}
        !== {1'b1, a, 1'b0}) begin
      errors++;
      $display("FAIL ovf_first got v%b %h o%b exp v1 %h o0",
               pix_if.pix_valid, pix_if.pix_data, overflow, a);
    end
    send_word(b, 0);
    vectors++;
    if ({pix_if.pix_valid, pix_if.pix_data, pix_if.pix_idx, overflow}
        !== {1'b1, a, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL ovf_held got v%b %h idx%0d o%b exp v1 %h idx0 o1",
               pix_if.pix_valid, pix_if.pix_data, pix_if.pix_idx,
               overflow, a);
    end
    step(0, 0, 0, 1, 0);
    vectors++;
    if ({pix_if.pix_valid, overflow} !== 2'b01) begin
      errors++;
      $display("FAIL ovf_drain got v%b o%b exp v0 o1",
               pix_if.pix_valid, overflow);
    end
  endtask

  task automatic test_short_frame();
    logic [23:0] w;
    w = 24'h0F0F81;
    step(1, 1, 0, 1, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 1, 1, 0);
    step(1, 1, 0, 1, 0);
    vectors++;
    if ({short_frame, frame_start} !== 2'b11) begin
      errors++;
      $display("FAIL short_pulse got sf%b fs%b exp 11",
               short_frame, frame_start);
    end
    step(1, 1, 0, 1, 0);
    vectors++;
    if ({short_frame, frame_start} !== 2'b01) begin
      errors++;
      $display("FAIL short_empty got sf%b fs%b exp 01",
               short_frame, frame_start);
    end
    send_word(w, 1);
    vectors++;
    if ({pix_if.pix_valid, pix_if.pix_data, pix_if.pix_idx}
        !== {1'b1, w, 2'd0}) begin
      errors++;
      $display("FAIL short_next got v%b %h idx%0d exp v1 %h idx0",
               pix_if.pix_valid, pix_if.pix_data, pix_if.pix_idx, w);
    end
  endtask

  task automatic test_rst_mid();
    step(1, 1, 0, 0, 0);
    send_word(24'h55AA55, 0);
    send_word(24'h000001, 0);
    step(0, 0, 0, 0, 1);
    vectors++;
    if ({pix_if.pix_valid, overflow} !== 2'b00) begin
      errors++;
      $display("FAIL rst_mid got v%b o%b exp v0 o0",
               pix_if.pix_valid, overflow);
    end
    send_word(24'hFFFFFF, 1);
    vectors++;
    if ({pix_if.pix_valid, frame_done} !== 2'b00) begin
      errors++;
      $display("FAIL rst_sync got v%b fd%b exp v0 fd0",
               pix_if.pix_valid, frame_done);
    end
  endtask

  task automatic test_random_back_to_back();
    bit s;
    bit sr;
    bit r;
    for (int c = 0; c < 3000; c++) begin
      r  = (c % 600 == 0);
      s  = ($urandom_range(0, 99) < 80);
      sr = s && ($urandom_range(0, 199) == 0);
      step(s, sr, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 99) < 60), r);
      vectors++;
      if (pix_if.pix_valid !== m_valid) begin
        errors++;
        $display("FAIL rnd_valid cyc %0d got %b exp %b",
                 c, pix_if.pix_valid, m_valid);
      end
      vectors++;
      if ({frame_start, frame_done, short_frame}
          !== {m_fs, m_fd, m_sf}) begin
        errors++;
        $display("FAIL rnd_pulses cyc %0d got %b%b%b exp %b%b%b", c,
                 frame_start, frame_done, short_frame, m_fs, m_fd, m_sf);
      end
      vectors++;
      if (overflow !== m_ovf) begin
        errors++;
        $display("FAIL rnd_ovf cyc %0d got %b exp %b", c, overflow, m_ovf);
      end
      if (m_valid) begin
        vectors++;
        if ({pix_if.pix_data, pix_if.pix_idx} !== {m_data, m_idx}) begin
          errors++;
          $display("FAIL rnd_word cyc %0d got %h/%0d exp %h/%0d", c,
                   pix_if.pix_data, pix_if.pix_idx, m_data, m_idx);
        end
      end
    end
  endtask

  initial begin
    rst              = 1'b1;
    bit_in           = 1'b0;
    bit_strobe       = 1'b0;
    bit_stream_reset = 1'b0;
    pix_if.pix_ready = 1'b0;
    test_reset();
    test_sync_ignore();
    test_single_word();
    test_frame_done();
    test_overflow();
    test_short_frame();
    test_rst_mid();
    test_random_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
